morse_sseg_scroller: RTL and testbench

Multi-digit successor to the single-digit Morse glyph decoder: accepts packed Morse symbol codes over a valid/ready handshake, decodes each to a seven-segment glyph and ASCII byte, and scrolls glyphs through a DIGITS-wide display buffer. A refresh counter time-multiplexes the buffer onto the board's common seven-segment bus. Sits between the Morse element timer/packer and the top-level SSEG/LED pins.

---
 rtl/morse_sseg_if.sv | 24 ++
 rtl/morse_sseg_scroller.sv | 187 ++++++++++++++++++
 tb/tb_morse_sseg_scroller.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/morse_sseg_if.sv
// Morse code handshake plus multiplexed seven-segment / ASCII outputs of the scroller.
interface morse_sseg_if #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned ERR_W  = 8
);
    logic [9:0]        code;
    logic              code_valid;
    logic              code_ready;
    logic [6:0]        sseg;
    logic [DIGITS-1:0] sseg_sel;
    logic [7:0]        ascii;
    logic              ascii_valid;
    logic [ERR_W-1:0]  err_cnt;

    modport master (
        output code, code_valid,
        input  code_ready, sseg, sseg_sel, ascii, ascii_valid, err_cnt
    );

    modport slave (
        input  code, code_valid,
        output code_ready, sseg, sseg_sel, ascii, ascii_valid, err_cnt
    );
endinterface

// File: rtl/morse_sseg_scroller.sv
// Decodes packed Morse symbols into glyphs/ASCII, scrolls them through a
// DIGITS-wide buffer and time-multiplexes the buffer onto a common sseg bus.
module morse_sseg_scroller #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned ERR_W       = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    morse_sseg_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(DIGITS);
    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

    localparam logic [1:0] OP_LETTER = 2'b00;
    localparam logic [1:0] OP_SPACE  = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_BKSP   = 2'b11;

    localparam logic [6:0] GLYPH_BLANK = 7'h7F;
    localparam logic [6:0] GLYPH_UNK   = 7'h3F;
    localparam logic [4:0] LETTER_NONE = 5'd31;

    localparam logic [6:0] GLYPH_ROM [26] = '{
        7'h20, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h42, 7'h0B, 7'h4F,
        7'h61, 7'h0A, 7'h47, 7'h6A, 7'h2B, 7'h40, 7'h0C, 7'h18, 7'h2F,
        7'h12, 7'h07, 7'h41, 7'h63, 7'h55, 7'h09, 7'h11, 7'h24
    };

    typedef enum logic {ST_READY, ST_HOLD} state_t;

    // Element key is {e4,e3,e2,e1}; any pattern not listed (gaps, 10 elements) is unknown.
    function automatic logic [4:0] f_letter(input logic [7:0] key);
        case (key)
            8'h0D: return 5'd0;   8'h57: return 5'd1;   8'h77: return 5'd2;
            8'h17: return 5'd3;   8'h01: return 5'd4;   8'h75: return 5'd5;
            8'h1F: return 5'd6;   8'h55: return 5'd7;   8'h05: return 5'd8;
            8'hFD: return 5'd9;   8'h37: return 5'd10;  8'h5D: return 5'd11;
            8'h0F: return 5'd12;  8'h07: return 5'd13;  8'h3F: return 5'd14;
            8'h7D: return 5'd15;  8'hDF: return 5'd16;  8'h1D: return 5'd17;
            8'h15: return 5'd18;  8'h03: return 5'd19;  8'h35: return 5'd20;
            8'hD5: return 5'd21;  8'h3D: return 5'd22;  8'hD7: return 5'd23;
            8'hF7: return 5'd24;  8'h5F: return 5'd25;
            default: return LETTER_NONE;
        endcase
    endfunction

    state_t                   r_state, w_state_nxt;
    logic                     r_code_ready;
    logic [1:0]               r_s1_op;
    logic [6:0]               r_s1_glyph;
    logic [7:0]               r_s1_ascii;
    logic                     r_s1_unk;
    logic [DIGITS-1:0][6:0]   r_buf, w_buf_nxt;
    logic [7:0]               r_ascii;
    logic                     r_ascii_valid;
    logic [ERR_W-1:0]         r_err_cnt;
    logic [CNT_W-1:0]         r_refresh;
    logic [IDX_W-1:0]         r_idx, w_idx_nxt;
    logic [6:0]               r_sseg;
    logic [DIGITS-1:0]        r_sseg_sel;

    logic [4:0]               w_letter;
    logic [6:0]               w_glyph;
    logic [7:0]               w_ascii;
    logic                     w_unk;
    logic                     w_accept;
    logic                     w_s1_vld;
    logic                     w_wrap;

    assign w_accept = (r_state == ST_READY) && bus.code_valid;
    assign w_s1_vld = (r_state == ST_HOLD);
    assign w_wrap   = (r_refresh == CNT_W'(REFRESH_DIV - 1));
    assign w_idx_nxt = (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);

    // Handshake FSM: one accepted code is followed by exactly one not-ready cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_READY;
            r_code_ready <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_code_ready <= (w_state_nxt == ST_READY);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_READY: if (bus.code_valid) w_state_nxt = ST_HOLD;
            ST_HOLD:  w_state_nxt = ST_READY;
            default:  w_state_nxt = ST_READY;
        endcase
    end

    // Stage-1 decode of the incoming symbol.
    always_comb begin
        w_letter = f_letter(bus.code[9:2]);
        w_unk    = 1'b0;
        w_glyph  = GLYPH_BLANK;
        w_ascii  = 8'd32;
        if (bus.code[1:0] == OP_LETTER) begin
            if (w_letter == LETTER_NONE) begin
                w_unk   = 1'b1;
                w_glyph = GLYPH_UNK;
                w_ascii = 8'd63;
            end else begin
                w_glyph = GLYPH_ROM[w_letter];
                w_ascii = 8'd65 + 8'(w_letter);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_op    <= OP_LETTER;
            r_s1_glyph <= GLYPH_BLANK;
            r_s1_ascii <= 8'd0;
            r_s1_unk   <= 1'b0;
        end else if (w_accept) begin
            r_s1_op    <= bus.code[1:0];
            r_s1_glyph <= w_glyph;
            r_s1_ascii <= w_ascii;
            r_s1_unk   <= w_unk;
        end
    end

    // Stage-2 buffer edit: shift-in, backspace shift-out, or clear.
    always_comb begin
        w_buf_nxt = r_buf;
        if (w_s1_vld) begin
            case (r_s1_op)
                OP_LETTER, OP_SPACE: begin
                    for (int i = DIGITS - 1; i > 0; i--)
                        w_buf_nxt[IDX_W'(i)] = r_buf[IDX_W'(i - 1)];
                    w_buf_nxt[0] = r_s1_glyph;
                end
                OP_BKSP: begin
                    for (int i = 0; i < DIGITS - 1; i++)
                        w_buf_nxt[IDX_W'(i)] = r_buf[IDX_W'(i + 1)];
                    w_buf_nxt[DIGITS-1] = GLYPH_BLANK;
                end
                default: w_buf_nxt = {DIGITS{GLYPH_BLANK}};
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf         <= {DIGITS{GLYPH_BLANK}};
            r_ascii       <= 8'd0;
            r_ascii_valid <= 1'b0;
            r_err_cnt     <= '0;
        end else begin
            r_buf         <= w_buf_nxt;
            r_ascii_valid <= w_s1_vld && (r_s1_op == OP_LETTER || r_s1_op == OP_SPACE);
            if (w_s1_vld && (r_s1_op == OP_LETTER || r_s1_op == OP_SPACE))
                r_ascii <= r_s1_ascii;
            if (w_s1_vld && (r_s1_op == OP_LETTER) && r_s1_unk && (r_err_cnt != '1))
                r_err_cnt <= r_err_cnt + ERR_W'(1);
        end
    end

    // Scan: digit select and segment data load together on each dwell wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refresh  <= '0;
            r_idx      <= '0;
            r_sseg     <= GLYPH_BLANK;
            r_sseg_sel <= ~DIGITS'(1);
        end else if (w_wrap) begin
            r_refresh  <= '0;
            r_idx      <= w_idx_nxt;
            r_sseg     <= w_buf_nxt[w_idx_nxt];
            r_sseg_sel <= ~(DIGITS'(1) << w_idx_nxt);
        end else begin
            r_refresh  <= r_refresh + CNT_W'(1);
        end
    end

    assign bus.code_ready  = r_code_ready;
    assign bus.sseg        = r_sseg;
    assign bus.sseg_sel    = r_sseg_sel;
    assign bus.ascii       = r_ascii;
    assign bus.ascii_valid = r_ascii_valid;
    assign bus.err_cnt     = r_err_cnt;
endmodule

// File: tb/tb_morse_sseg_scroller.sv
// Directed bench for morse_sseg_scroller: handshake, latency, scrolling, scan and saturation.
module tb_morse_sseg_scroller;
    localparam int unsigned DIGITS = 4;
    localparam int unsigned RDIV   = 4;
    localparam int unsigned ERR_W  = 4;
    localparam int unsigned FRAME  = DIGITS * RDIV;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    morse_sseg_if #(.DIGITS(DIGITS), .ERR_W(ERR_W)) bus ();

    morse_sseg_scroller #(.DIGITS(DIGITS), .REFRESH_DIV(RDIV), .ERR_W(ERR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [9:0] c);
        int t;
        t = 0;
        while (!bus.code_ready && t < 8) begin
            tick();
            t++;
        end
        check("ready_before_send", 32'(bus.code_ready), 32'd1);
        bus.code       = c;
        bus.code_valid = 1'b1;
        tick();
        bus.code_valid = 1'b0;
        check("ready_low_after_accept", 32'(bus.code_ready), 32'd0);
    endtask

    task automatic send_chk(input logic [9:0] c, input logic pulse, input logic [7:0] exp_ascii);
        send(c);
        check("av_not_yet", 32'(bus.ascii_valid), 32'd0);
        tick();
        check("ready_back", 32'(bus.code_ready), 32'd1);
        check("av_pulse", 32'(bus.ascii_valid), 32'(pulse));
        check("ascii", 32'(bus.ascii), 32'(exp_ascii));
        tick();
        check("av_one_cycle", 32'(bus.ascii_valid), 32'd0);
    endtask

    task automatic chk_buf(input string tag, input logic [DIGITS-1:0][6:0] exp);
        logic [DIGITS-1:0] want_sel;
        int t;
        repeat (FRAME + 1) tick();
        for (int k = DIGITS - 1; k >= 0; k--) begin
            want_sel = ~(DIGITS'(1) << k);
            t = 0;
            while (bus.sseg_sel != want_sel && t < int'(FRAME) + 2) begin
                tick();
                t++;
            end
            check($sformatf("%s_sel%0d", tag, k), 32'(bus.sseg_sel), 32'(want_sel));
            check($sformatf("%s_dig%0d", tag, k), 32'(bus.sseg), 32'(exp[k]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int accepts;
        int pulses;
        bus.code       = 10'h000;
        bus.code_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_sseg", 32'(bus.sseg), 32'h7F);
        check("rst_sel", 32'(bus.sseg_sel), 32'hE);
        check("rst_ready", 32'(bus.code_ready), 32'd1);
        check("rst_ascii", 32'(bus.ascii), 32'd0);
        check("rst_av", 32'(bus.ascii_valid), 32'd0);
        check("rst_err", 32'(bus.err_cnt), 32'd0);

        // Scan dwell and wrap
        @(negedge clk) rst_n = 1'b1;
        repeat (3) tick();
        check("dwell_hold", 32'(bus.sseg_sel), 32'hE);
        tick();
        check("scan_d1", 32'(bus.sseg_sel), 32'hD);
        repeat (RDIV) tick();
        check("scan_d2", 32'(bus.sseg_sel), 32'hB);
        repeat (RDIV) tick();
        check("scan_d3", 32'(bus.sseg_sel), 32'h7);
        repeat (RDIV) tick();
        check("scan_wrap", 32'(bus.sseg_sel), 32'hE);
        repeat (RDIV + 1) tick();
        check("pre_rst_sel", 32'(bus.sseg_sel), 32'hD);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_sel", 32'(bus.sseg_sel), 32'hE);
        check("async_rst_sseg", 32'(bus.sseg), 32'h7F);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // S O S
        send_chk(10'h054, 1'b1, 8'd83);
        send_chk(10'h0FC, 1'b1, 8'd79);
        send_chk(10'h054, 1'b1, 8'd83);
        chk_buf("sos", {7'h7F, 7'h12, 7'h40, 7'h12});

        // Clear, then A..E overflows the four digits
        send_chk(10'h002, 1'b0, 8'd83);
        send_chk(10'h034, 1'b1, 8'd65);
        send_chk(10'h15C, 1'b1, 8'd66);
        send_chk(10'h1DC, 1'b1, 8'd67);
        send_chk(10'h05C, 1'b1, 8'd68);
        send_chk(10'h004, 1'b1, 8'd69);
        chk_buf("abcde", {7'h03, 7'h46, 7'h21, 7'h06});

        // Element after a gap is unknown
        send_chk(10'h3C4, 1'b1, 8'd63);
        check("err_one", 32'(bus.err_cnt), 32'd1);
        chk_buf("unk", {7'h46, 7'h21, 7'h06, 7'h3F});
        send_chk(10'h002, 1'b0, 8'd63);
        chk_buf("clear", {7'h7F, 7'h7F, 7'h7F, 7'h7F});

        // Backspace and space
        send_chk(10'h004, 1'b1, 8'd69);
        send_chk(10'h00C, 1'b1, 8'd84);
        chk_buf("et", {7'h7F, 7'h7F, 7'h06, 7'h07});
        send_chk(10'h003, 1'b0, 8'd84);
        chk_buf("bksp", {7'h7F, 7'h7F, 7'h7F, 7'h06});
        send_chk(10'h001, 1'b1, 8'd32);
        chk_buf("space", {7'h7F, 7'h7F, 7'h06, 7'h7F});

        // Continuous valid: accepted every second cycle, err_cnt saturates
        accepts = 0;
        pulses  = 0;
        bus.code       = 10'h3C4;
        bus.code_valid = 1'b1;
        for (int i = 0; i < 38; i++) begin
            if (bus.code_ready) accepts++;
            tick();
            if (bus.ascii_valid) pulses++;
        end
        bus.code_valid = 1'b0;
        tick();
        if (bus.ascii_valid) pulses++;
        tick();
        check("stream_accepts", 32'(accepts), 32'd19);
        check("stream_pulses", 32'(pulses), 32'd19);
        check("err_saturated", 32'(bus.err_cnt), 32'd15);
        check("stream_ascii", 32'(bus.ascii), 32'd63);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
